// File: rtl/demux_pair_pkg.sv
// Shared types for the demux_pair block: the phase FSM states and the
// default pair layout used downstream of the alternating 2:1 mux.
package demux_pair_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        S_FIRST  = 1'b0,
        S_SECOND = 1'b1
    } phase_t;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] lane1;
        logic [DEFAULT_WIDTH-1:0] lane0;
    } pair_t;

endpackage

// File: rtl/demux_pair_pair_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; when empty the head
// output holds the most recently popped word (zero after reset).
module pair_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] last_pop;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs, even when full.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? last_pop : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_pop <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                last_pop <= mem[rd_ptr[AW-1:0]];
                rd_ptr   <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_pair.sv
// Rebuilds two lanes from the mux's interleaved stream (first word -> lane 1)
// and queues completed pairs behind a valid/ready interface.
module demux_pair
    import demux_pair_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out_1,
    output logic [WIDTH-1:0] data_out_0,
    output logic             overflow,
    output logic [CNT_W-1:0] pair_count
);

    typedef struct packed {
        logic [WIDTH-1:0] lane1;
        logic [WIDTH-1:0] lane0;
    } lane_pair_t;

    phase_t           phase;
    logic [WIDTH-1:0] hold_1;
    logic             pair_done;
    logic             pop;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    lane_pair_t       new_pair;
    lane_pair_t       head_pair;

    assign pair_done = (phase == S_SECOND) && valid_in;
    assign pop       = valid_out && ready_out;
    assign push      = pair_done && (!fifo_full || pop);
    assign new_pair  = '{lane1: hold_1, lane0: data_in};

    assign valid_out  = !fifo_empty;
    assign data_out_1 = head_pair.lane1;
    assign data_out_0 = head_pair.lane0;

    pair_fifo #(
        .W     (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (new_pair),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_pair)
    );

    // A completed pair always returns the FSM to S_FIRST, dropped or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= S_FIRST;
            hold_1     <= '0;
            overflow   <= 1'b0;
            pair_count <= '0;
        end else begin
            case (phase)
                S_FIRST: begin
                    if (valid_in) begin
                        hold_1 <= data_in;
                        phase  <= S_SECOND;
                    end
                end
                S_SECOND: begin
                    if (valid_in) begin
                        phase <= S_FIRST;
                    end
                end
                default: phase <= S_FIRST;
            endcase
            if (push) begin
                pair_count <= pair_count + CNT_W'(1);
            end
            if (pair_done && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
